// File: rtl/gf_basis_conv_stream_pkg.sv
// gf_basis_pkg: mode encodings, legal field widths and lane-slice helpers for the basis converter
package gf_basis_pkg;
  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_A2T  = 2'b01,
    MODE_T2A  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;
  localparam int GF_BITS_16  = 4;
  localparam int GF_BITS_256 = 8;
  function automatic bit gf_bits_legal(input int b);
    return b == GF_BITS_16 || b == GF_BITS_256;
  endfunction
  function automatic int slice_w(input int lanes, input int gf_bits);
    return lanes * gf_bits;
  endfunction
endpackage

// File: rtl/gf_basis_conv_stream_if.sv
// gf_basis_conv_stream_if: input and output valid/ready streams of the basis converter
interface gf_basis_conv_stream_if #(
  parameter int GF_BITS = 8,
  parameter int LANES   = 16
);
  import gf_basis_pkg::*;
  localparam int W = slice_w(LANES, GF_BITS);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_mode;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  modport master (output in_valid, in_mode, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_mode, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/gf_basis_conv_stream_lane.sv
// gf_basis_lane: one-element AES/tower basis change, combinational
module gf_basis_lane
  import gf_basis_pkg::*;
#(
  parameter int GF_BITS = 8
) (
  input  logic [GF_BITS-1:0] a,
  input  mode_e              mode,
  output logic [GF_BITS-1:0] c
);
  logic [GF_BITS-1:0] a2t, t2a;
  if (GF_BITS == GF_BITS_256) begin : g_256
    assign a2t = {a[5]^a[7], a[1]^a[2]^a[3]^a[4]^a[6]^a[7], a[2]^a[3], a[4]^a[5]^a[6],
                  a[3]^a[5]^a[6], a[2]^a[3]^a[4]^a[7], a[2]^a[4]^a[5], a[0]^a[1]};
    assign t2a = {a[1]^a[3]^a[4]^a[5]^a[7], a[2]^a[4]^a[5]^a[7], a[1]^a[3]^a[4]^a[5],
                  a[1]^a[2]^a[3]^a[4]^a[7], a[1]^a[2]^a[7], a[1]^a[2]^a[5]^a[7],
                  a[4]^a[5]^a[6]^a[7], a[0]^a[4]^a[5]^a[6]^a[7]};
  end else if (GF_BITS == GF_BITS_16) begin : g_16
    assign a2t = {a[3], a[1]^a[2]^a[3], a[2]^a[3], a[0]};
    assign t2a = {a[3], a[1]^a[3], a[1]^a[2], a[0]};
  end else begin : g_none
    assign a2t = a;
    assign t2a = a;
  end
  always_comb c = mode == MODE_A2T ? a2t : mode == MODE_T2A ? t2a : a;
endmodule

// File: rtl/gf_basis_conv_stream.sv
// gf_basis_conv_stream: two-stage valid/ready pipeline converting LANES field elements per beat between bases
module gf_basis_conv_stream
  import gf_basis_pkg::*;
#(
  parameter int GF_BITS = 8,
  parameter int LANES   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  gf_basis_conv_stream_if.slave  bus,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic                   mode_err
);
  localparam int W = slice_w(LANES, GF_BITS);
  if (!gf_bits_legal(GF_BITS) || LANES < 1 || LANES > 64) begin : g_bad_param
    $error("gf_basis_conv_stream: illegal GF_BITS or LANES");
  end
  logic [W-1:0]     s1_data_q, s1_data_d, s2_data_q, s2_data_d, conv;
  mode_e            s1_mode_q, s1_mode_d;
  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_en, in_ready, hs;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gf_basis_lane #(.GF_BITS(GF_BITS)) u_lane (
      .a    (s1_data_q[i*GF_BITS +: GF_BITS]),
      .mode (s1_mode_q),
      .c    (conv[i*GF_BITS +: GF_BITS])
    );
  end
  always_comb begin
    s2_en     = !s2_v_q || bus.out_ready;
    in_ready  = !s1_v_q || s2_en;
    hs        = bus.in_valid && in_ready;
    s1_v_d    = in_ready ? bus.in_valid : s1_v_q;
    s1_data_d = hs ? bus.in_data : s1_data_q;
    s1_mode_d = hs ? mode_e'(bus.in_mode) : s1_mode_q;
    s2_v_d    = s2_en ? s1_v_q : s2_v_q;
    s2_data_d = s2_en && s1_v_q ? conv : s2_data_q;
    cnt_d     = hs ? cnt_q + CNT_W'(1) : cnt_q;
    err_d     = err_q || (hs && bus.in_mode == MODE_RSVD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_mode_q <= MODE_PASS;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_mode_q <= s1_mode_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_v_q;
  assign bus.out_data  = s2_data_q;
  assign beat_cnt      = cnt_q;
  assign mode_err      = err_q;
endmodule

// File: tb/tb_gf_basis_conv_stream.sv
// tb_gf_basis_conv_stream: three lockstep converter instances checked against directed tables and a mask-based model
module tb_gf_basis_conv_stream;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [1:0]  in_mode;
  logic [7:0]  d8;
  logic [63:0] d64;
  logic [15:0] d16;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  logic        err_a, err_b, err_c;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  gf_basis_conv_stream_if #(.GF_BITS(8), .LANES(1))  ia ();
  gf_basis_conv_stream_if #(.GF_BITS(4), .LANES(16)) ib ();
  gf_basis_conv_stream_if #(.GF_BITS(8), .LANES(2))  ic ();
  assign ia.in_valid = in_valid;
  assign ia.in_mode = in_mode;
  assign ia.in_data = d8;
  assign ia.out_ready = out_ready;
  assign ib.in_valid = in_valid;
  assign ib.in_mode = in_mode;
  assign ib.in_data = d64;
  assign ib.out_ready = out_ready;
  assign ic.in_valid = in_valid;
  assign ic.in_mode = in_mode;
  assign ic.in_data = d16;
  assign ic.out_ready = out_ready;
  gf_basis_conv_stream #(.GF_BITS(8), .LANES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave), .beat_cnt(cnt_a), .mode_err(err_a));
  gf_basis_conv_stream #(.GF_BITS(4), .LANES(16), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave), .beat_cnt(cnt_b), .mode_err(err_b));
  gf_basis_conv_stream #(.GF_BITS(8), .LANES(2), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .bus(ic.slave), .beat_cnt(cnt_c), .mode_err(err_c));
  localparam logic [63:0] A2T8 = 64'hA0DE0C70689C3403;
  localparam logic [63:0] T2A8 = 64'hBAB43A9E86A6F0F1;
  localparam logic [63:0] A2T4 = 64'h00000000080E0C01;
  localparam logic [63:0] T2A4 = 64'h00000000080A0601;
  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  d8, e8;
    logic [63:0] d64, e64;
  } vec_t;
  typedef struct {
    logic [7:0]  e8;
    logic [63:0] e64;
    logic [15:0] e16;
  } exp_t;
  vec_t vecs[8];
  exp_t q[$];
  function automatic logic [7:0] par_map(input logic [7:0] x, input logic [63:0] m);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ^(x & m[i*8 +: 8]);
    return r;
  endfunction
  function automatic logic [7:0] model8(input logic [1:0] m, input logic [7:0] x);
    return m == 2'd1 ? par_map(x, A2T8) : m == 2'd2 ? par_map(x, T2A8) : x;
  endfunction
  function automatic logic [63:0] model64(input logic [1:0] m, input logic [63:0] x);
    logic [63:0] r;
    logic [7:0]  t;
    for (int l = 0; l < 16; l++) begin
      t = m == 2'd1 ? par_map({4'h0, x[l*4 +: 4]}, A2T4) : m == 2'd2 ? par_map({4'h0, x[l*4 +: 4]}, T2A4) : {4'h0, x[l*4 +: 4]};
      r[l*4 +: 4] = t[3:0];
    end
    return r;
  endfunction
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic send(input logic [1:0] m, input logic [7:0] x8, input logic [63:0] x64, input logic [15:0] x16);
    in_valid = 1'b1;
    in_mode = m;
    d8 = x8;
    d64 = x64;
    d16 = x16;
    out_ready = 1'b1;
    #1 chk("send_in_ready", 64'(ia.in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("latency_cycle1_valid", 64'(ia.out_valid), 64'd0);
    @(posedge clk);
    #1 chk("latency_cycle2_valid", 64'(ia.out_valid), 64'd1);
  endtask
  initial begin
    logic [63:0] t64;
    logic        hold;
    logic [7:0]  held;
    int          acc, cyc;
    exp_t        e;
    vecs[0] = '{2'd1, 8'h02, 8'h41, {16{4'h2}}, {16{4'h4}}};
    vecs[1] = '{2'd2, 8'h41, 8'h02, {16{4'h4}}, {16{4'h2}}};
    vecs[2] = '{2'd0, 8'h5A, 8'h5A, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    vecs[3] = '{2'd1, 8'h80, 8'hC4, {16{4'h8}}, {16{4'hE}}};
    vecs[4] = '{2'd2, 8'h10, 8'hF3, {16{4'h8}}, {16{4'hC}}};
    vecs[5] = '{2'd1, 8'hFF, 8'h1A, {16{4'hF}}, {16{4'hD}}};
    vecs[6] = '{2'd2, 8'h01, 8'h01, {16{4'h1}}, {16{4'h1}}};
    vecs[7] = '{2'd1, 8'h01, 8'h01, 64'h0, 64'h0};
    in_mode = 2'd0;
    d8 = '0;
    d64 = '0;
    d16 = '0;
    out_ready = 1'b1;
    do_reset;
    chk("reset_in_ready", 64'(ia.in_ready), 64'd1);
    chk("reset_out_valid", 64'({ia.out_valid, ib.out_valid, ic.out_valid}), 64'd0);
    chk("reset_out_data_a", 64'(ia.out_data), 64'd0);
    chk("reset_out_data_b", ib.out_data, 64'd0);
    chk("reset_beat_cnt", 64'({cnt_a, cnt_c}), 64'd0);
    chk("reset_mode_err", 64'({err_a, err_b, err_c}), 64'd0);
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mode, vecs[i].d8, vecs[i].d64, {vecs[i].d8, vecs[i].d8});
      chk($sformatf("vec%0d_a", i), 64'(ia.out_data), 64'(vecs[i].e8));
      chk($sformatf("vec%0d_b", i), ib.out_data, vecs[i].e64);
      chk($sformatf("vec%0d_c", i), 64'(ic.out_data), 64'({vecs[i].e8, vecs[i].e8}));
    end
    chk("no_mode_err", 64'(err_a), 64'd0);
    send(2'd1, 8'h00, 64'hFEDCBA9876543210, 16'h0);
    chk("exhaustive_a2t", ib.out_data, model64(2'd1, 64'hFEDCBA9876543210));
    t64 = ib.out_data;
    send(2'd2, 8'h00, t64, 16'h0);
    chk("exhaustive_roundtrip", ib.out_data, 64'hFEDCBA9876543210);
    send(2'd3, 8'h33, {16{4'h3}}, 16'h3333);
    chk("rsvd_data_a", 64'(ia.out_data), 64'h33);
    chk("rsvd_data_b", ib.out_data, {16{4'h3}});
    chk("rsvd_mode_err", 64'({err_a, err_b, err_c}), 64'h7);
    do_reset;
    chk("mode_err_cleared", 64'(err_a), 64'd0);
    out_ready = 1'b0;
    in_mode = 2'd0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      d8 = 8'h10 + 8'(i);
      #1 if (ia.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd2);
    chk("bp_in_ready_low", 64'(ia.in_ready), 64'd0);
    chk("bp_hold_data", 64'({ia.out_valid, ia.out_data}), 64'h110);
    out_ready = 1'b1;
    #1 chk("bp_release_first", 64'({ia.out_valid, ia.out_data}), 64'h110);
    @(posedge clk);
    #1 chk("bp_release_second", 64'({ia.out_valid, ia.out_data}), 64'h111);
    @(posedge clk);
    #1 chk("bp_release_empty", 64'(ia.out_valid), 64'd0);
    do_reset;
    in_valid = 1'b1;
    repeat (17) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("cnt_wrap_c", 64'(cnt_c), 64'd1);
    chk("cnt_a_17", 64'(cnt_a), 64'd17);
    do_reset;
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("inflight_valid", 64'(ic.out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    chk("midrst_out_valid", 64'(ic.out_valid), 64'd0);
    chk("midrst_beat_cnt", 64'(cnt_c), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("midrst_no_emit", 64'({ia.out_valid, ic.out_valid}), 64'd0);
    end
    do_reset;
    acc = 0;
    cyc = 0;
    hold = 1'b0;
    held = '0;
    while (acc < 1000 && cyc < 8000) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_mode = 2'($urandom_range(0, 2));
      d8 = 8'($urandom);
      d64 = {$urandom, $urandom};
      d16 = 16'($urandom);
      out_ready = $urandom_range(0, 9) < 6;
      #1;
      if (hold) chk("stall_stable", 64'({ia.out_valid, ia.out_data}), 64'({1'b1, held}));
      if (ia.out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_unexpected_beat", 64'(ia.out_data), 64'hx);
        else begin
          e = q.pop_front();
          chk("rand_a", 64'(ia.out_data), 64'(e.e8));
          chk("rand_b", ib.out_data, e.e64);
          chk("rand_c", 64'(ic.out_data), 64'(e.e16));
        end
      end
      if (in_valid && ia.in_ready) begin
        q.push_back('{model8(in_mode, d8), model64(in_mode, d64), {model8(in_mode, d16[15:8]), model8(in_mode, d16[7:0])}});
        acc++;
      end
      hold = ia.out_valid && !out_ready;
      held = ia.out_data;
      @(posedge clk);
      #1 cyc++;
    end
    chk("rand_accepts", 64'(acc), 64'd1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      #1;
      if (ia.out_valid) begin
        e = q.pop_front();
        chk("drain_a", 64'(ia.out_data), 64'(e.e8));
        chk("drain_b", ib.out_data, e.e64);
        chk("drain_c", 64'(ic.out_data), 64'(e.e16));
      end
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("rand_beat_cnt_a", 64'(cnt_a), 64'd1000);
    chk("rand_beat_cnt_c", 64'(cnt_c), 64'd8);
    chk("rand_no_mode_err", 64'(err_a), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
